// File: rtl/csum_pkg.sv
// Shared types and constants for the ones'-complement checksum checker.
// Holds the FSM state encoding, the default data width and the counter width.
package csum_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam int CSUM_WIDTH = 4;
    localparam int ERR_CNT_W  = 8;

endpackage

// File: rtl/oc_add.sv
// Combinational WIDTH-bit ones'-complement adder with end-around carry.
// Ports: a, b (operands), sum (folded result).
module oc_add
    import csum_pkg::*;
#(
    parameter int WIDTH = CSUM_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH:0] w_t;

    assign w_t = {1'b0, a} + {1'b0, b};

    // A single fold is enough: after folding, the add cannot carry again.
    assign sum = w_t[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, w_t[WIDTH]};

endmodule

// File: rtl/oc_checksum_check.sv
// Receive-side ones'-complement checksum checker over valid/ready frames.
// Ports: clk, rst_n; in_valid/in_ready/in_data/in_last (word stream);
//        out_valid/out_ready/out_ok/out_sum (frame result);
//        err_cnt (failed-frame count, present only with CSUM_ERR_CNT_EN).
module oc_checksum_check
    import csum_pkg::*;
#(
    parameter int WIDTH = CSUM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_ok,
`ifdef CSUM_ERR_CNT_EN
    output logic [WIDTH-1:0]     out_sum,
    output logic [ERR_CNT_W-1:0] err_cnt
`else
    output logic [WIDTH-1:0]     out_sum
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_ok;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_beat;
    logic             w_done;

    oc_add #(
        .WIDTH (WIDTH)
    ) u_add (
        .a   (r_acc),
        .b   (in_data),
        .sum (w_acc_nxt)
    );

    assign in_ready  = (r_state != RESULT);
    assign out_valid = (r_state == RESULT);
    assign out_sum   = r_sum;
    assign out_ok    = r_ok;
    assign w_beat    = in_valid & in_ready;
    assign w_done    = out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, ACCUM: begin
                if (w_beat) begin
                    w_state_nxt = in_last ? RESULT : ACCUM;
                end
            end
            RESULT: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_sum <= '0;
            r_ok  <= 1'b0;
        end else begin
            if (w_beat) begin
                r_acc <= w_acc_nxt;
                if (in_last) begin
                    r_sum <= w_acc_nxt;
                    r_ok  <= (w_acc_nxt == {WIDTH{1'b1}});
                end
            end
            if (w_done) begin
                r_acc <= '0;
            end
        end
    end

`ifdef CSUM_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_done && !r_ok && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_oc_checksum_check.sv
// Directed self-checking bench for oc_checksum_check (WIDTH = 4).
// Build with +define+CSUM_ERR_CNT_EN to also cover the error counter.
module tb_oc_checksum_check;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic       out_ok;
    logic [3:0] out_sum;
`ifdef CSUM_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int n_err;
    int n_chk;

    oc_checksum_check #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ok    (out_ok),
`ifdef CSUM_ERR_CNT_EN
        .out_sum   (out_sum),
        .err_cnt   (err_cnt)
`else
        .out_sum   (out_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the last beat; checks one-cycle latency too.
    task automatic result(input string tag, input logic [3:0] s,
                          input logic ok);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_sum"}, 32'(out_sum), 32'(s));
        check({tag, "_ok"}, 32'(out_ok), 32'(ok));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_drop"}, 32'(out_valid), 0);
        check({tag, "_rdy"}, 32'(in_ready), 1);
    endtask

    initial begin
        n_err     = 0;
        n_chk     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_ok", 32'(out_ok), 0);
        check("rst_out_sum", 32'(out_sum), 0);
`ifdef CSUM_ERR_CNT_EN
        check("rst_err_cnt", 32'(err_cnt), 0);
`endif
        rst_n = 1'b1;

        send(4'h3, 1'b0);
        send(4'h5, 1'b0);
        check("f1_pre_valid", 32'(out_valid), 0);
        send(4'h7, 1'b1);
        result("f1", 4'hF, 1'b1);

        send(4'h9, 1'b0);
        send(4'hA, 1'b0);
        send(4'hB, 1'b1);
        result("carry", 4'hF, 1'b1);

        send(4'h9, 1'b0);
        send(4'hA, 1'b0);
        send(4'hA, 1'b1);
        result("bad", 4'hE, 1'b0);
`ifdef CSUM_ERR_CNT_EN
        check("bad_err_cnt", 32'(err_cnt), 1);
`endif

        send(4'hF, 1'b1);
        result("oneF", 4'hF, 1'b1);

        send(4'hF, 1'b0);
        send(4'hF, 1'b1);
        result("twoF", 4'hF, 1'b1);

        send(4'h0, 1'b1);
        result("zero", 4'h0, 1'b0);
`ifdef CSUM_ERR_CNT_EN
        check("zero_err_cnt", 32'(err_cnt), 2);
`endif

        // Backpressure: result held, a waiting word must not be taken.
        send(4'h9, 1'b0);
        send(4'hA, 1'b0);
        send(4'hB, 1'b1);
        @(negedge clk);
        check("bp_valid0", 32'(out_valid), 1);
        in_valid = 1'b1;
        in_data  = 4'hF;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_sum", 32'(out_sum), 32'hF);
            check("bp_ok", 32'(out_ok), 1);
            check("bp_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_bubble_valid", 32'(out_valid), 0);
        check("bp_bubble_rdy", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        result("bp_next", 4'hF, 1'b1);

        // Asynchronous reset mid-frame discards the partial sum.
        send(4'h3, 1'b0);
        send(4'h5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_in_ready", 32'(in_ready), 1);
        check("mid_out_valid", 32'(out_valid), 0);
        check("mid_out_ok", 32'(out_ok), 0);
        check("mid_out_sum", 32'(out_sum), 0);
`ifdef CSUM_ERR_CNT_EN
        check("mid_err_cnt", 32'(err_cnt), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        send(4'h7, 1'b1);
        result("after_rst", 4'h7, 1'b0);
`ifdef CSUM_ERR_CNT_EN
        check("after_rst_err_cnt", 32'(err_cnt), 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
